// File: rtl/mram_pkg.sv
// Shared parameters, state encoding and control bundle
// for the serial-to-MRAM bridge.
package mram_pkg;

  localparam int ADDR_W    = 20;
  localparam int DATA_W    = 16;
  localparam int FRAME_LEN = 20;
  localparam int WR_CYCLES = 2;
  localparam int RD_CYCLES = 2;
  localparam int CNT_W     = 5;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SHIFT = 3'd1,
    S_WRITE = 3'd2,
    S_READ  = 3'd3,
    S_SER   = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  // Active-low MRAM strobes, grouped so they move together
  typedef struct packed {
    logic ce_n;
    logic we_n;
    logic oe_n;
    logic lb_n;
    logic ub_n;
  } ctrl_t;

  localparam ctrl_t CTRL_OFF = ctrl_t'(5'b11111);
  localparam ctrl_t CTRL_WR  = ctrl_t'(5'b00100);
  localparam ctrl_t CTRL_RD  = ctrl_t'(5'b01000);

endpackage

// File: rtl/mram_serial_to_parallel.sv
// LSB-first deserializer: each enabled edge writes the
// next bit position; partial words are visible in place.
module serial_to_parallel #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             ser_in,
  output logic [WIDTH-1:0] par_out
);

  localparam int PW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] par_q, par_d;
  logic [PW-1:0]    pos_q, pos_d;

  // Place the incoming bit at the current position
  always_comb begin
    par_d = par_q;
    pos_d = pos_q;
    if (clr) begin
      pos_d = '0;
    end else if (en && pos_q < PW'(WIDTH)) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (pos_q == PW'(i)) par_d[i] = ser_in;
      end
      pos_d = pos_q + 1'b1;
    end
  end

  // Register word and position
  always_ff @(posedge clk) begin
    if (rst) begin
      par_q <= '0;
      pos_q <= '0;
    end else begin
      par_q <= par_d;
      pos_q <= pos_d;
    end
  end

  assign par_out = par_q;

endmodule

// File: rtl/mram_top_module.sv
// Serial frame to parallel MRAM write/read sequencer
// with serialized readback.
module mram_top_module
  import mram_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              data_in,
  input  logic              addr_in,
  input  logic              read_write_sel,
  output logic [DATA_W-1:0] data_out,
  output logic [ADDR_W-1:0] addr_out,
  input  logic [DATA_W-1:0] parallel_data_in,
  output logic              ser_data_out,
  output logic              chip_en,
  output logic              write_en,
  output logic              out_en,
  output logic              lower_byte_en,
  output logic              upper_byte_en
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              op_q, op_d;
  logic [DATA_W-1:0] rd_q, rd_d;
  ctrl_t             ctrl_q, ctrl_d;
  logic              ser_q, ser_d;
  logic [3:0]        nxt;
  logic              shifting;
  logic              clr;
  logic              data_en;

  assign shifting = (state_q == S_SHIFT);
  assign clr      = (state_q == S_IDLE);
  assign data_en  = shifting && (cnt_q < CNT_W'(DATA_W));
  assign nxt      = cnt_q[3:0] + 4'd1;

  serial_to_parallel #(.WIDTH(ADDR_W)) u_addr (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .en      (shifting),
    .ser_in  (addr_in),
    .par_out (addr_out)
  );

  serial_to_parallel #(.WIDTH(DATA_W)) u_data (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .en      (data_en),
    .ser_in  (data_in),
    .par_out (data_out)
  );

  // Sequencer: next state, counters and registered outputs
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    rd_d    = rd_q;
    ctrl_d  = CTRL_OFF;
    ser_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        op_d    = read_write_sel;
        cnt_d   = '0;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (cnt_q == CNT_W'(FRAME_LEN - 1)) begin
          cnt_d = '0;
          if (op_q) begin
            state_d = S_WRITE;
            ctrl_d  = CTRL_WR;
          end else begin
            state_d = S_READ;
            ctrl_d  = CTRL_RD;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WRITE: begin
        if (cnt_q == CNT_W'(WR_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d  = cnt_q + 1'b1;
          ctrl_d = CTRL_WR;
        end
      end
      S_READ: begin
        if (cnt_q == CNT_W'(RD_CYCLES - 1)) begin
          cnt_d   = '0;
          rd_d    = parallel_data_in;
          ser_d   = parallel_data_in[0];
          state_d = S_SER;
        end else begin
          cnt_d  = cnt_q + 1'b1;
          ctrl_d = CTRL_RD;
        end
      end
      S_SER: begin
        if (cnt_q == CNT_W'(DATA_W - 1)) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
          ser_d = rd_q[nxt];
        end
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= 1'b0;
      rd_q    <= '0;
      ctrl_q  <= CTRL_OFF;
      ser_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      ctrl_q  <= ctrl_d;
      ser_q   <= ser_d;
    end
  end

  assign chip_en       = ctrl_q.ce_n;
  assign write_en      = ctrl_q.we_n;
  assign out_en        = ctrl_q.oe_n;
  assign lower_byte_en = ctrl_q.lb_n;
  assign upper_byte_en = ctrl_q.ub_n;
  assign ser_data_out  = ser_q;

endmodule

// File: tb/tb_mram_top_module.sv
// Randomized frame bench for mram_top_module with a
// timeline reference model.
module tb_mram_top_module;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        data_in = 1'b0;
  logic        addr_in = 1'b0;
  logic        read_write_sel = 1'b0;
  logic [15:0] data_out;
  logic [19:0] addr_out;
  logic [15:0] parallel_data_in = 16'h0;
  logic        ser_data_out;
  logic        chip_en;
  logic        write_en;
  logic        out_en;
  logic        lower_byte_en;
  logic        upper_byte_en;

  int n_vec = 0;
  int n_err = 0;

  mram_top_module dut (
    .clk              (clk),
    .rst              (rst),
    .data_in          (data_in),
    .addr_in          (addr_in),
    .read_write_sel   (read_write_sel),
    .data_out         (data_out),
    .addr_out         (addr_out),
    .parallel_data_in (parallel_data_in),
    .ser_data_out     (ser_data_out),
    .chip_en          (chip_en),
    .write_en         (write_en),
    .out_en           (out_en),
    .lower_byte_en    (lower_byte_en),
    .upper_byte_en    (upper_byte_en)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] low_bits(
      input logic [31:0] v, input int n);
    logic [31:0] m;
    m = (n >= 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
    return v & m;
  endfunction

  function automatic logic [4:0] ctrl_vec();
    return {chip_en, write_en, out_en,
            lower_byte_en, upper_byte_en};
  endfunction

  // Edge 0 is IDLE; edges 1..20 carry frame bit e-1;
  // MRAM access spans the 2 cycles after edge 20; read
  // data is taken at edge 22 and shifted out after
  // edges 22..37.
  task automatic run_frame(input bit op,
                           input logic [19:0] a,
                           input logic [15:0] d,
                           input logic [15:0] p,
                           input int abort_e,
                           input int len,
                           input string nm);
    logic [4:0]  c_exp;
    logic        s_exp;
    logic [31:0] a_exp, d_exp;
    rst = 1'b1;
    @(posedge clk); #1;
    chk({nm, ".rst.addr"}, 32'(addr_out), 32'h0);
    chk({nm, ".rst.data"}, 32'(data_out), 32'h0);
    chk({nm, ".rst.ctrl"}, 32'(ctrl_vec()), 32'h1F);
    chk({nm, ".rst.ser"}, 32'(ser_data_out), 32'h0);
    for (int e = 0; e < len; e++) begin
      rst = (e >= abort_e);
      read_write_sel = (e == 0) ? op : 1'($urandom);
      addr_in = (e >= 1 && e <= 20) ? a[e-1]
                                    : 1'($urandom);
      data_in = (e >= 1 && e <= 16) ? d[e-1]
                                    : 1'($urandom);
      parallel_data_in = (e == 22) ? p : 16'($urandom);
      @(posedge clk); #1;
      if (e >= abort_e) begin
        a_exp = 32'h0;
        d_exp = 32'h0;
        c_exp = 5'h1F;
        s_exp = 1'b0;
      end else begin
        a_exp = low_bits(32'(a), (e < 20) ? e : 20);
        d_exp = low_bits(32'(d), (e < 16) ? e : 16);
        c_exp = 5'h1F;
        if (e == 20 || e == 21)
          c_exp = op ? 5'b00100 : 5'b01000;
        s_exp = 1'b0;
        if (!op && e >= 22 && e <= 37)
          s_exp = p[e-22];
      end
      chk($sformatf("%s.e%0d.addr", nm, e),
          32'(addr_out), a_exp);
      chk($sformatf("%s.e%0d.data", nm, e),
          32'(data_out), d_exp);
      chk($sformatf("%s.e%0d.ctrl", nm, e),
          32'(ctrl_vec()), 32'(c_exp));
      chk($sformatf("%s.e%0d.ser", nm, e),
          32'(ser_data_out), 32'(s_exp));
    end
  endtask

  localparam int NO_ABORT = 1 << 20;

  initial begin
    repeat (2) @(posedge clk);
    run_frame(1'b1, 20'h00000, 16'h03FF, 16'h0,
              NO_ABORT, 42, "wr");
    run_frame(1'b0, 20'hFFFFF, 16'h0, 16'hA5C3,
              NO_ABORT, 42, "rd");
    run_frame(1'b1, 20'h00001, 16'h8001, 16'h0,
              NO_ABORT, 24, "a_lsb");
    run_frame(1'b0, 20'h80000, 16'h0, 16'h0001,
              NO_ABORT, 40, "a_msb");
    run_frame(1'b1, 20'h5A5A5, 16'h1234, 16'h0,
              11, 30, "ab_shift");
    run_frame(1'b0, 20'hABCDE, 16'h0, 16'hFFFF,
              27, 45, "ab_ser");
    run_frame(1'b1, 20'h12345, 16'hBEEF, 16'h0,
              NO_ABORT, 140, "hold_wr");
    run_frame(1'b0, 20'h6789A, 16'h0, 16'h6A5C,
              NO_ABORT, 140, "hold_rd");
    for (int i = 0; i < 24; i++) begin
      run_frame(1'($urandom), 20'($urandom),
                16'($urandom), 16'($urandom),
                (i % 4 == 3) ? int'($urandom_range(0, 40))
                             : NO_ABORT,
                42, $sformatf("rnd%0d", i));
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mram_top_module.md
MRAM_TOP_MODULE -- requirements
Module: mram_top_module

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk input 1 (all state updates on its rising edge); rst input 1 (synchronous, active-high).
REQ-002 The block SHALL have these data ports: data_in input 1 (serial write data, LSB first); addr_in input 1 (serial address, LSB first); read_write_sel input 1 (1=write, 0=read).
REQ-003 The block SHALL have these MRAM-side data ports: data_out output 16 (parallel write data to MRAM); addr_out output 20 (parallel address to MRAM); parallel_data_in input 16 (MRAM read data); ser_data_out output 1 (serial read data, LSB first).
REQ-004 The block SHALL have these MRAM control ports, all active-low: chip_en output 1; write_en output 1; out_en output 1; lower_byte_en output 1; upper_byte_en output 1.

Function
REQ-005 The FSM SHALL have states IDLE, SHIFT, WRITE, READ, SER, DONE, all registered.
REQ-006 IDLE SHALL last exactly 1 cycle after reset release: latch read_write_sel into op, clear bit counter, go to SHIFT.
REQ-007 SHIFT SHALL last 20 cycles; on edge k (k=0..19) it SHALL sample addr_in into address bit k, and for k<16 sample data_in into data bit k; data_in on k=16..19 SHALL be ignored.
REQ-008 read_write_sel SHALL be ignored outside IDLE.
REQ-009 After the 20th SHIFT edge the FSM SHALL go to WRITE if op=1, else to READ.
REQ-010 addr_out SHALL always equal the address register; data_out SHALL always equal the data register (partially filled values visible during SHIFT).
REQ-011 WRITE SHALL last 2 cycles with chip_en=0, write_en=0, out_en=1, lower_byte_en=0, upper_byte_en=0, then go to DONE.
REQ-012 READ SHALL last 2 cycles with chip_en=0, out_en=0, write_en=1, lower_byte_en=0, upper_byte_en=0; on its last edge it SHALL capture parallel_data_in into a read register and go to SER.
REQ-013 SER SHALL last 16 cycles, driving ser_data_out = read register bit i in cycle i (i=0..15, LSB first), then go to DONE.
REQ-014 ser_data_out SHALL be 0 outside SER.
REQ-015 Outside WRITE/READ, all control outputs SHALL be 1 (inactive).
REQ-016 DONE SHALL hold with controls inactive until rst; a new frame requires reset.
REQ-017 Control outputs and ser_data_out SHALL be registered, changing only on the clock edge that enters/leaves a state.

Reset
REQ-018 While rst=1 at a rising edge: state=IDLE, counter=0, op=0, address/data/read registers=0, addr_out=0, data_out=0, ser_data_out=0, all five control outputs=1.
REQ-019 Reset asserted mid-operation (any state) SHALL abort it at that edge; no further MRAM strobes occur.

Structure
REQ-020 A shared package SHALL hold ADDR_W=20, DATA_W=16, FRAME_LEN=20, WR_CYCLES=2, RD_CYCLES=2 and the state enum.
REQ-021 One parameterised sub-module, serial_to_parallel (WIDTH, shift-enable, LSB-first), SHALL be instantiated for address (20) and data (16); FSM, readback serializer and controls stay in the top.

Verification
REQ-022 Write: reset, read_write_sel=1, addr_in=0 for 20 bits, data_in=1 for 10 bits then 0 for 10 -> data_out=16'h03FF, addr_out=20'h00000, write_en/chip_en/byte enables low exactly 2 cycles, out_en stays high.
REQ-023 Read: read_write_sel=0, addr_in=1 for 20 bits, parallel_data_in=16'hA5C3 -> addr_out=20'hFFFFF, out_en/chip_en low 2 cycles, write_en high, ser_data_out emits 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1 then 0.
REQ-024 Address ordering: addr_in=1 only on bit 0 -> addr_out=20'h00001; only on bit 19 -> 20'h80000.
REQ-025 Reset mid-SHIFT (after 10 bits) and mid-SER (after 5 bits) -> next edge all controls 1, ser_data_out=0, registers 0, no WRITE/READ strobe.
REQ-026 read_write_sel toggled during SHIFT -> operation follows value latched in IDLE; DONE holds controls inactive for 100 cycles.
